// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider controller: gated clk_out with start/stop, run length and graceful stop.
// Optional macro CLK_DIV_CTRL_DYN_DIV_EN reloads the divisor at every falling edge of clk_out.
module clk_div_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] num_periods,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] periods_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] phase_cnt;
  logic [DIV_W-1:0] div_eff;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] pd_next;
  logic             stop_pend;
  logic             phase_end;

  assign div_eff   = (div == '0) ? DIV_W'(1) : div;
  assign phase_end = (phase_cnt == div_q - DIV_W'(1));
  assign pd_next   = periods_done + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_q        <= '0;
      num_q        <= '0;
      phase_cnt    <= '0;
      stop_pend    <= 1'b0;
      clk_out      <= 1'b0;
      tick         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      periods_done <= '0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          clk_out <= 1'b0;
          if (start) begin
            div_q        <= div_eff;
            num_q        <= num_periods;
            periods_done <= '0;
            phase_cnt    <= '0;
            stop_pend    <= 1'b0;
            clk_out      <= 1'b1;
            tick         <= 1'b1;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (stop && !clk_out && phase_end) begin
            // Stop on the last low cycle: that low phase is already full length.
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            phase_cnt <= '0;
          end else if (phase_end) begin
            phase_cnt <= '0;
            clk_out   <= ~clk_out;
            if (!clk_out) begin
              tick <= 1'b1;
            end else begin
              periods_done <= pd_next;
              if (stop_pend || stop || (num_q != '0 && pd_next == num_q))
                state <= DRAIN;
`ifdef CLK_DIV_CTRL_DYN_DIV_EN
              div_q <= div_eff;
`endif
            end
          end else begin
            phase_cnt <= phase_cnt + DIV_W'(1);
            if (stop) begin
              if (clk_out) stop_pend <= 1'b1;
              else         state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (phase_end) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable clock-divider controller that generates a divided, gated clock `clk_out` from `clk`. It has start/stop commands, a run length in output periods, and a graceful stop that always ends a full period with `clk_out` low. It sequences clock generation for benches and test harnesses, replacing free-running clock loops so simulation finishes cleanly once the run length is reached.

Parameters:
DIV_W, 8, width of half-period divisor input
CNT_W, 16, width of period count input and completed-period counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  start request, sampled when IDLE
stop  input  1  graceful stop request, sampled when RUN
div  input  DIV_W  half-period length in clk cycles; 0 treated as 1
num_periods  input  CNT_W  output periods to generate; 0 = free-run until stop
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse coincident with each rising edge of clk_out
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse on return to IDLE
periods_done  output  CNT_W  count of falling edges of clk_out since last accepted start

Behaviour:
- Clock: one clock, `clk`. Reset: `rst_n`, asynchronous, active-low.
- Reset, asserted at any time including mid-run:
  - state=IDLE, clk_out=0, tick=0, busy=0, done=0, periods_done=0, all internal registers 0. This takes effect immediately, not at the next edge.
- All outputs are registered.
- Internal state:
  - `div_q`: latched divisor, equal to max(div,1).
  - `num_q`: latched num_periods.
  - `phase_cnt`: DIV_W bits.
  - `stop_pend`: 1 bit.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - clk_out=0.
  - On an edge with start=1: latch div_q and num_q; clear periods_done, phase_cnt and stop_pend. Next cycle clk_out=1, tick=1, busy=1, state=RUN.
  - stop is ignored in IDLE. If start=1 and stop=1 together, start is accepted and stop is discarded.
- RUN, on each edge:
  - If phase_cnt==div_q-1: toggle clk_out and set phase_cnt=0. Otherwise phase_cnt++.
  - Each phase therefore lasts exactly div_q cycles; period = 2*div_q cycles.
  - Rising toggle: tick=1 for that cycle.
  - Falling toggle: periods_done++. Go to DRAIN if stop_pend=1, or if num_q!=0 and the new periods_done==num_q. Otherwise stay in RUN.
    - Final-period check happens at the falling edge; DRAIN then holds the final low phase.
  - stop=1 while clk_out=1: set stop_pend; the current period completes.
  - stop=1 while clk_out=0: go directly to DRAIN. phase_cnt continues counting, so the current low phase completes at its original length.
  - start is ignored in RUN.
- DRAIN:
  - clk_out stays 0; phase_cnt counts.
  - When phase_cnt==div_q-1: state=IDLE, busy=0, done=1 for exactly one cycle, phase_cnt=0.
  - start and stop are ignored in DRAIN.
  - periods_done is not incremented in DRAIN.
- periods_done:
  - Holds its value after done until the next accepted start.
  - Wraps modulo 2^CNT_W in free-run.
- start accepted in the same cycle done is high is a normal IDLE start. The preceding low phase was already a full div_q cycles.
- Latency: start edge to first clk_out rise is 1 cycle. Last falling edge to done is div_q cycles.
- div and num_periods are sampled only at start; changes mid-run have no effect, except as described under Optional Feature.

Optional Feature:
- Macro: CLK_DIV_CTRL_DYN_DIV_EN.
- Defined: div_q is reloaded with max(div,1) at every falling toggle of clk_out in RUN. The new half-period applies from the following low phase, so the divisor changes only on period boundaries with no partial phases.
- Not defined: div_q is fixed from start until IDLE.

Test Plan:
- div=2, num_periods=3, start at edge 0:
  - clk_out high cycles 1-2, 5-6, 9-10; low elsewhere.
  - tick at cycles 1, 5, 9.
  - busy high cycles 1-12; done=1 at cycle 13 only; periods_done=3.
- div=0, num_periods=2:
  - clk_out = 1,0,1,0 over cycles 1-4.
  - done at cycle 5; periods_done=2.
- div=3, num_periods=0, stop pulsed at cycle 8 (second high phase):
  - Period completes: high through cycle 9, low cycles 10-12.
  - done at cycle 13; periods_done=2.
- div=3, num_periods=0, stop pulsed at cycle 5 (first low phase):
  - Goes to DRAIN; low continues through cycle 6.
  - done at cycle 7; periods_done=1; no further tick.
- rst_n dropped mid-high-phase at cycle 4:
  - clk_out, busy and periods_done go to 0 immediately, with no done pulse.
  - After release, start with div=1, num_periods=1 gives clk_out 1,0 then done.
- start pulses during busy and stop in IDLE are ignored. start and stop together in IDLE with div=1, num_periods=2 run a full 2 periods.
  - With CLK_DIV_CTRL_DYN_DIV_EN defined: change div from 1 to 2 during the first high phase; second period is low 2, high 2, low 2 cycles.
